// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions used by the control FSM, datapath and K ROM.
//   state_t       : control FSM state encodings
//   SHA256_ROUNDS : compression rounds per block in full SHA-256
//   SCHED_START   : first round whose W[t] comes from the sigma schedule
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ROUNDS = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int SHA256_ROUNDS = 64;
    localparam int SCHED_START   = 16;

endpackage

// File: rtl/sha256_round_cnt.sv
// Round index counter for the SHA-256 compression engine.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous clear to 0 (wins over en)
//   en           : advance the index by one
//   idx          : current round number t
//   tc           : terminal count, idx == NUM_ROUNDS-1
module sha256_round_cnt #(
    parameter int NUM_ROUNDS = 64,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] idx,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ROUNDS - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (en) begin
            idx <= idx + 1'b1;
        end
    end

    assign tc = (idx == LAST_IDX);

endmodule

// File: rtl/sha256_core_ct.sv
// Control FSM of the SHA-256 compression engine. Responds to a level-held
// init by sequencing block load, working-state load, NUM_ROUNDS rounds and
// the digest add, then holds digest_valid until init is seen low.
//   clk, reset_n   : clock, asynchronous active-low reset
//   init           : level request, held until digest_valid is seen
//   first_block    : 1 = load a..h from IV, 0 = from prev_hash
//   load_block     : W[0..15] <= block_in
//   load_state     : a..h <= IV / prev_hash
//   sel_iv         : first_block latched when the block starts
//   round_en       : run one round this cycle
//   round_idx      : round number t (0 outside ROUNDS)
//   w_sched        : W[t] comes from the schedule (t >= 16)
//   update_digest  : H <= H_in + a..h
//   digest_valid   : digest output valid
//   busy           : FSM not idle
module sha256_core_ct
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = SHA256_ROUNDS,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             init,
    input  logic             first_block,
    output logic             load_block,
    output logic             load_state,
    output logic             sel_iv,
    output logic             round_en,
    output logic [CNT_W-1:0] round_idx,
    output logic             w_sched,
    output logic             update_digest,
    output logic             digest_valid,
    output logic             busy
);

    localparam logic [CNT_W-1:0] SCHED_IDX = CNT_W'(SCHED_START);

    state_t state;
    state_t state_nxt;
    logic   cnt_clear;
    logic   cnt_en;
    logic   cnt_tc;

    // Counter runs only in ROUNDS and is cleared everywhere else, so it
    // reads 0 in LOAD and returns to 0 on the last round.
    assign cnt_en    = (state == ST_ROUNDS);
    assign cnt_clear = (state != ST_ROUNDS) || cnt_tc;

    sha256_round_cnt #(
        .NUM_ROUNDS (NUM_ROUNDS),
        .CNT_W      (CNT_W)
    ) u_round_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .en      (cnt_en),
        .idx     (round_idx),
        .tc      (cnt_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // IV/prev_hash select is captured only on the IDLE->LOAD edge; later
    // first_block changes belong to the next block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_iv <= 1'b0;
        end else if ((state == ST_IDLE) && init) begin
            sel_iv <= first_block;
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        unique case (state)
            ST_IDLE:   state_nxt = init ? ST_LOAD : ST_IDLE;
            ST_LOAD:   state_nxt = ST_ROUNDS;
            ST_ROUNDS: state_nxt = cnt_tc ? ST_UPDATE : ST_ROUNDS;
            ST_UPDATE: state_nxt = ST_DONE;
            ST_DONE:   state_nxt = init ? ST_DONE : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Moore decode; unused encodings fall to the all-zero default.
    always_comb begin
        load_block    = 1'b0;
        load_state    = 1'b0;
        round_en      = 1'b0;
        w_sched       = 1'b0;
        update_digest = 1'b0;
        digest_valid  = 1'b0;
        busy          = 1'b0;
        unique case (state)
            ST_LOAD: begin
                load_block = 1'b1;
                load_state = 1'b1;
                busy       = 1'b1;
            end
            ST_ROUNDS: begin
                round_en = 1'b1;
                w_sched  = (round_idx >= SCHED_IDX);
                busy     = 1'b1;
            end
            ST_UPDATE: begin
                update_digest = 1'b1;
                busy          = 1'b1;
            end
            ST_DONE: begin
                digest_valid = 1'b1;
                busy         = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sha256_core_ct.sv
// Testbench for sha256_core_ct. The reference model tracks only how many
// cycles have elapsed since a block started (phase) and derives every output
// from that phase using the documented latency timeline.
module tb_sha256_core_ct;

    localparam int N     = 64;
    localparam int CNT_W = 6;
    localparam int VW    = 8 + CNT_W;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             init = 1'b0;
    logic             first_block = 1'b0;
    logic             load_block;
    logic             load_state;
    logic             sel_iv;
    logic             round_en;
    logic [CNT_W-1:0] round_idx;
    logic             w_sched;
    logic             update_digest;
    logic             digest_valid;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    // Model: phase 0 = idle, 1 = load, 2..N+1 = rounds, N+2 = update, N+3 = done.
    int   m_phase = 0;
    logic m_sel   = 1'b0;

    sha256_core_ct #(.NUM_ROUNDS(N), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .init          (init),
        .first_block   (first_block),
        .load_block    (load_block),
        .load_state    (load_state),
        .sel_iv        (sel_iv),
        .round_en      (round_en),
        .round_idx     (round_idx),
        .w_sched       (w_sched),
        .update_digest (update_digest),
        .digest_valid  (digest_valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [VW-1:0] obs_vec();
        return {load_block, load_state, sel_iv, round_en, round_idx,
                w_sched, update_digest, digest_valid, busy};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic             ren;
        logic [CNT_W-1:0] idx;
        ren = (m_phase >= 2) && (m_phase <= N + 1);
        idx = ren ? CNT_W'(m_phase - 2) : '0;
        return {m_phase == 1, m_phase == 1, m_sel, ren, idx,
                ren && (m_phase - 2 >= 16), m_phase == N + 2,
                m_phase == N + 3, m_phase != 0};
    endfunction

    // Advance one clock, update the model with the inputs present at the
    // edge, and return 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            m_phase = 0;
            m_sel   = 1'b0;
        end else if (m_phase == 0) begin
            if (init) begin
                m_phase = 1;
                m_sel   = first_block;
            end
        end else if (m_phase < N + 3) begin
            m_phase++;
        end else if (!init) begin
            m_phase = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            init        = 1'($urandom);
            first_block = 1'($urandom);
            tick();
            checks++;
            if (obs_vec() !== '0) begin
                failures++;
                $display("FAIL reset_outputs i=%0d got=%h expected=%h", i, obs_vec(), {VW{1'b0}});
            end
        end
        init    = 1'b0;
        reset_n = 1'b1;
        tick();
        checks++;
        if (obs_vec() !== exp_vec() || busy !== 1'b0 || round_idx !== '0) begin
            failures++;
            $display("FAIL reset_release got=%h expected=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single_block();
        int first_dv = -1;
        int upd_cnt  = 0;
        int ws_rise  = -1;
        first_block = 1'b1;
        init        = 1'b1;
        for (int k = 1; k <= N + 8; k++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL single_cycle k=%0d got=%h expected=%h", k, obs_vec(), exp_vec());
            end
            if (digest_valid && first_dv < 0) first_dv = k;
            if (update_digest) upd_cnt++;
            if (w_sched && ws_rise < 0) ws_rise = int'(round_idx);
        end
        checks++;
        if (first_dv !== N + 3) begin
            failures++;
            $display("FAIL single_latency got=%0d expected=%0d", first_dv, N + 3);
        end
        checks++;
        if (upd_cnt !== 1) begin
            failures++;
            $display("FAIL single_update_count got=%0d expected=1", upd_cnt);
        end
        checks++;
        if (ws_rise !== 16) begin
            failures++;
            $display("FAIL single_wsched_rise got=%0d expected=16", ws_rise);
        end
        init = 1'b0;
        tick();
        checks++;
        if (obs_vec() !== exp_vec() || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_return_idle got=%h expected=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_chain();
        logic fb_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic sel_seen [4];
        int   loads   = 0;
        int   upd_cnt = 0;
        for (int b = 0; b < 4; b++) begin
            bit done_seen = 0;
            first_block = fb_seq[b];
            init        = 1'b1;
            sel_seen[b] = 1'bx;
            for (int k = 1; k <= N + 20 && !done_seen; k++) begin
                tick();
                if (k == 1) first_block = 1'($urandom);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL chain_cycle blk=%0d k=%0d got=%h expected=%h", b, k, obs_vec(), exp_vec());
                end
                if (load_state) begin
                    loads++;
                    sel_seen[b] = sel_iv;
                end
                if (update_digest) upd_cnt++;
                if (digest_valid) done_seen = 1;
            end
            if (!done_seen) begin
                failures++;
                $display("FAIL chain_timeout blk=%0d digest_valid=0 expected=1", b);
            end
            init = 1'b0;
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL chain_gap blk=%0d got=%h expected=%h", b, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (upd_cnt !== 4 || loads !== 4) begin
            failures++;
            $display("FAIL chain_counts updates=%0d loads=%0d expected=4,4", upd_cnt, loads);
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (sel_seen[b] !== fb_seq[b]) begin
                failures++;
                $display("FAIL chain_sel_iv blk=%0d got=%b expected=%b", b, sel_seen[b], fb_seq[b]);
            end
        end
    endtask

    task automatic test_hold_done();
        int  hold;
        bit  done_seen = 0;
        first_block = 1'($urandom);
        init        = 1'b1;
        for (int k = 1; k <= N + 20 && !done_seen; k++) begin
            tick();
            if (digest_valid) done_seen = 1;
        end
        checks++;
        if (!done_seen || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL hold_reach_done got=%h expected=%h", obs_vec(), exp_vec());
        end
        hold = $urandom_range(3, 10);
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (digest_valid !== 1'b1 || load_block !== 1'b0 || obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL hold_stay_done i=%0d got=%h expected=%h", i, obs_vec(), exp_vec());
            end
        end
        init = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL hold_to_idle got=%h expected=%h", obs_vec(), exp_vec());
        end
        init        = 1'b1;
        first_block = 1'b0;
        tick();
        checks++;
        if (load_state !== 1'b1 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL hold_restart got=%h expected=%h", obs_vec(), exp_vec());
        end
        for (int k = 2; k <= N + 3; k++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL hold_second_block k=%0d got=%h expected=%h", k, obs_vec(), exp_vec());
            end
        end
        init = 1'b0;
        tick();
    endtask

    task automatic test_drop_early();
        int dv_cycles = 0;
        int first_dv  = -1;
        first_block = 1'b1;
        init        = 1'b1;
        for (int k = 1; k <= N + 8; k++) begin
            tick();
            if (round_en && round_idx == CNT_W'(10)) init = 1'b0;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL drop_cycle k=%0d got=%h expected=%h", k, obs_vec(), exp_vec());
            end
            if (digest_valid) begin
                dv_cycles++;
                if (first_dv < 0) first_dv = k;
            end
        end
        checks++;
        if (dv_cycles !== 1 || first_dv !== N + 3) begin
            failures++;
            $display("FAIL drop_dv_pulse width=%0d at=%0d expected=1 at %0d", dv_cycles, first_dv, N + 3);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL drop_idle busy=%b expected=0", busy);
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        int first_dv = -1;
        first_block = 1'b1;
        init        = 1'b1;
        for (int k = 1; k <= N && !hit; k++) begin
            tick();
            if (round_en && round_idx == CNT_W'(30)) hit = 1;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL rstmid_reach_round30 got=0 expected=1");
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== '0) begin
            failures++;
            $display("FAIL rstmid_async got=%h expected=%h", obs_vec(), {VW{1'b0}});
        end
        m_phase = 0;
        m_sel   = 1'b0;
        init    = 1'b0;
        #2 reset_n = 1'b1;
        tick();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL rstmid_idle got=%h expected=%h", obs_vec(), exp_vec());
        end
        init        = 1'b1;
        first_block = 1'b0;
        for (int k = 1; k <= N + 5; k++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rstmid_rerun k=%0d got=%h expected=%h", k, obs_vec(), exp_vec());
            end
            if (digest_valid && first_dv < 0) first_dv = k;
        end
        checks++;
        if (first_dv !== N + 3) begin
            failures++;
            $display("FAIL rstmid_latency got=%0d expected=%0d", first_dv, N + 3);
        end
        init = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            init        = ($urandom_range(0, 3) != 0);
            first_block = 1'($urandom);
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_cycle i=%0d got=%h expected=%h", i, obs_vec(), exp_vec());
            end
        end
        init = 1'b0;
        for (int i = 0; i < N + 4; i++) tick();
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_chain();
        test_hold_done();
        test_drop_early();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
